// File: rtl/regfile_sb_if.sv
// Register file / scoreboard bus: two read ports, two write ports, one issue port.
// The master side drives addresses, writes and issues; the slave side is the register file.
interface regfile_sb_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    ra_addr, rb_addr;
    logic [WIDTH-1:0] ra_data, rb_data;
    logic             ra_busy, rb_busy;
    logic             we0, we1;
    logic [AW-1:0]    wa0, wa1;
    logic [WIDTH-1:0] wd0, wd1;
    logic             iss_valid;
    logic [AW-1:0]    iss_addr;
    logic             iss_ready;
    logic [AW:0]      busy_cnt;

    modport master (
        output ra_addr, rb_addr, we0, we1, wa0, wa1, wd0, wd1, iss_valid, iss_addr,
        input  ra_data, rb_data, ra_busy, rb_busy, iss_ready, busy_cnt
    );
    modport slave (
        input  ra_addr, rb_addr, we0, we1, wa0, wa1, wd0, wd1, iss_valid, iss_addr,
        output ra_data, rb_data, ra_busy, rb_busy, iss_ready, busy_cnt
    );
endinterface

// File: rtl/regfile_sb.sv
// 2R/2W register file with a per-register busy scoreboard and busy counter.
// Define REGFILE_SB_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_sb #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1
) (
    input logic         clk,
    input logic         rst_n,
    regfile_sb_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam bit ZR = (ZERO_REG != 0);

    logic [DEPTH-1:0][WIDTH-1:0] regs;
    logic [DEPTH-1:0]            busy, busy_nxt, clr, rise, fall;
    logic [AW:0]                 cnt, n_rise, n_fall;
    logic                        wz0, wz1, iss_blk, iss_acc;

    assign wz0 = ZR && (bus.wa0 == '0);
    assign wz1 = ZR && (bus.wa1 == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else begin
            if (bus.we0 && !wz0) regs[bus.wa0] <= bus.wd0;
            // port 1 is assigned last so it wins an address collision
            if (bus.we1 && !wz1) regs[bus.wa1] <= bus.wd1;
        end
    end

    always_comb begin
        clr = '0;
        for (int i = 0; i < DEPTH; i++)
            clr[i] = (bus.we0 && bus.wa0 == AW'(i)) || (bus.we1 && bus.wa1 == AW'(i));
    end

    assign iss_blk       = busy[bus.iss_addr] && !clr[bus.iss_addr];
    assign iss_acc       = bus.iss_valid && !iss_blk;
    assign bus.iss_ready = !iss_blk;

    // a same-cycle issue overrides the write's clear, so the register stays busy
    always_comb begin
        busy_nxt = busy;
        n_rise   = '0;
        n_fall   = '0;
        for (int i = 0; i < DEPTH; i++)
            busy_nxt[i] = (iss_acc && bus.iss_addr == AW'(i) && !(ZR && i == 0)) ||
                          (busy[i] && !clr[i]);
        rise = busy_nxt & ~busy;
        fall = busy & ~busy_nxt;
        for (int i = 0; i < DEPTH; i++) begin
            n_rise = n_rise + {{AW{1'b0}}, rise[i]};
            n_fall = n_fall + {{AW{1'b0}}, fall[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
            cnt  <= '0;
        end else begin
            busy <= busy_nxt;
            cnt  <= cnt + n_rise - n_fall;
        end
    end

    assign bus.busy_cnt = cnt;

    logic [1:0][AW-1:0]    raddr;
    logic [1:0][WIDTH-1:0] rdata;
    logic [1:0]            rbusy, hit0, hit1;

    assign raddr = {bus.rb_addr, bus.ra_addr};

    always_comb begin
        rdata = '0;
        rbusy = '0;
        hit0  = '0;
        hit1  = '0;
        for (int p = 0; p < 2; p++) begin
            hit0[p]  = bus.we0 && (bus.wa0 == raddr[p]);
            hit1[p]  = bus.we1 && (bus.wa1 == raddr[p]);
            rdata[p] = regs[raddr[p]];
`ifdef REGFILE_SB_BYPASS_EN
            if (hit1[p])      rdata[p] = bus.wd1;
            else if (hit0[p]) rdata[p] = bus.wd0;
`endif
            // zero masking follows the bypass so r0 stays zero even when forwarded
            if (ZR && raddr[p] == '0) rdata[p] = '0;
            if (!rst_n)               rdata[p] = '0;
            rbusy[p] = busy[raddr[p]] && !hit0[p] && !hit1[p];
        end
    end

    assign bus.ra_data = rdata[0];
    assign bus.rb_data = rdata[1];
    assign bus.ra_busy = rbusy[0];
    assign bus.rb_busy = rbusy[1];
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data bits per register.
REQ-002 SHALL have parameter DEPTH, default 32, register count; power of two, >= 4; AW = log2(DEPTH) derived locally.
REQ-003 SHALL have parameter ZERO_REG, default 1, 1 = register 0 reads as zero, ignores writes and is never busy.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports ra_addr, rb_addr  input  AW  read-port A and B addresses.
REQ-007 SHALL have ports ra_data, rb_data  output  WIDTH  read data, combinational.
REQ-008 SHALL have ports ra_busy, rb_busy  output  1  addressed register has a pending producer.
REQ-009 SHALL have ports we0, we1  input  1  write-port enables.
REQ-010 SHALL have ports wa0, wa1  input  AW  write addresses.
REQ-011 SHALL have ports wd0, wd1  input  WIDTH  write data.
REQ-012 SHALL have port iss_valid  input  1  issue request: mark iss_addr as pending.
REQ-013 SHALL have port iss_addr  input  AW  destination register of the issue.
REQ-014 SHALL have port iss_ready  output  1  issue accepted this cycle when iss_valid and iss_ready are both high.
REQ-015 SHALL have port busy_cnt  output  AW+1  number of registers currently marked busy.

Function
REQ-016 SHALL perform writes on the rising clk edge for each port with we high; both ports may write in the same cycle.
REQ-017 SHALL, when we0 and we1 target the same address in the same cycle, store wd1 (port 1 wins).
REQ-018 SHALL, when ZERO_REG=1, drop writes to address 0 and return 0 for reads of address 0.
REQ-019 SHALL hold one busy bit per register, set on an accepted issue and cleared by any write to that register.
REQ-020 SHALL drive ra_busy/rb_busy high when the addressed busy bit is set and no write to that address is enabled this cycle.
REQ-021 SHALL drive iss_ready low only when the busy bit of iss_addr is set and no write clears it this cycle (WAW hold); otherwise high.
REQ-022 SHALL, when an accepted issue and a write target the same address in one cycle, store the write data and leave the busy bit set (issue wins).
REQ-023 SHALL accept issues to address 0 when ZERO_REG=1 without setting a busy bit.
REQ-024 SHALL update busy_cnt in the same edge as the busy bits, with a net change in the range -2..+1 per cycle; it SHALL never exceed DEPTH or underflow.
REQ-025 SHALL leave the busy bit unchanged on a write to a non-busy register, and busy_cnt unchanged by that write.

Reset
REQ-026 SHALL, while rst_n is low, asynchronously clear all registers to 0, all busy bits to 0 and busy_cnt to 0.
REQ-027 SHALL, during reset, present ra_data=rb_data=0, ra_busy=rb_busy=0 and iss_ready=1; a reset mid-operation discards all pending state.

Configuration
REQ-028 SHALL honour macro REGFILE_SB_BYPASS_EN: when defined, a read whose address matches an enabled write in the same cycle returns that write data (port 1 over port 0); when undefined, reads return the stored value until the next edge.
REQ-029 SHALL apply ZERO_REG masking after the bypass in both configurations.

Verification
REQ-030 SHALL cover reset: all regs preloaded, pulse rst_n low between edges -> immediately ra_data=0, busy_cnt=0, iss_ready=1.
REQ-031 SHALL cover dual write: wa0=wa1=5, wd0=0x11, wd1=0x22 -> reg5=0x22 after the edge; we0 wa0=0 wd0=0xFF -> ra_addr=0 reads 0.
REQ-032 SHALL cover scoreboard: issue 7 -> ra_busy(7)=1, busy_cnt=1; second issue 7 -> iss_ready=0; write 7 with 0xAB -> busy_cnt=0, ra_data=0xAB.
REQ-033 SHALL cover a simultaneous event: issue 9 and write 9 (0x55) in one cycle -> reg9=0x55, busy(9) still 1, busy_cnt=1.
REQ-034 SHALL cover bypass: write 3 with 0x77 and read 3 in the same cycle -> 0x77 with REGFILE_SB_BYPASS_EN defined, the old value without it.
REQ-035 SHALL cover busy_cnt limits: issue all DEPTH-1 non-zero registers -> busy_cnt=31; clear two per cycle via both ports -> decrement by 2 per cycle to 0.
